// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the MIPS datapath: widths, write-back source
// select, memory-stage FSM states and the EX/MEM and MEM/WB latch payloads.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    // Write-back source; encoding 3 is reserved and treated as ALU.
    typedef enum logic [1:0] {
        REG_ALU  = 2'd0,
        REG_LOAD = 2'd1,
        REG_LINK = 2'd2
    } regsel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } memstate_t;

    typedef struct packed {
        logic [WORD_W-1:0] npc;
        logic              dren;
        logic              dwen;
        logic              regwr;
        regsel_t           regsel;
        logic [REG_W-1:0]  regdst;
        logic [WORD_W-1:0] aluout;
        logic [WORD_W-1:0] rtdat;
    } exmem_t;

    typedef struct packed {
        logic              regwr;
        logic [REG_W-1:0]  regdst;
        logic [WORD_W-1:0] wdat;
    } memwb_t;

    // Dcache addresses are word granular.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-cache request sequencer for the memory stage.
// Ports: CLK/RST; advance (pipeline moves this cycle); start (a memory op is
// being captured into EX/MEM); dren/dwen of the latched op; dhit/dmemload
// from the dcache; dmemREN/dmemWEN requests; mem_stall; load_q/ld_valid hold
// load data that returned while the pipeline could not advance.
module dmem_req_fsm
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              advance,
    input  logic              start,
    input  logic              dren,
    input  logic              dwen,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              mem_stall,
    output logic [WORD_W-1:0] load_q,
    output logic              ld_valid
);

    memstate_t state_q;
    memstate_t state_d;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and request outputs. A dhit cycle may also advance a new
    // memory op into EX/MEM, which starts its access straight away.
    always_comb begin
        state_d   = state_q;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                dmemWEN   = dwen;
                dmemREN   = dren & ~dwen;
                mem_stall = ~dhit;
                if (dhit) begin
                    state_d = start ? ACCESS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load data capture; ld_valid marks data that arrived without an advance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            load_q   <= '0;
            ld_valid <= 1'b0;
        end else begin
            if (dmemREN && dhit) begin
                load_q <= dmemload;
            end
            if (advance) begin
                ld_valid <= 1'b0;
            end else if (dmemREN && dhit) begin
                ld_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM latch, dcache request
// handshake, write-back value select and MEM/WB latch.
// Ports: CLK/RST; ihit/flush pipeline control; ex_* execute-stage results;
// dhit/dmemload and dmemREN/dmemWEN/dmemaddr/dmemstore dcache interface;
// mem_stall upstream hold; fwd_* forwarding info; wb_* MEM/WB latch.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              flush,
    input  logic [WORD_W-1:0] ex_nPC,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic              ex_regWr,
    input  logic [1:0]        ex_regSel,
    input  logic [REG_W-1:0]  ex_regDst,
    input  logic [WORD_W-1:0] ex_ALUOut,
    input  logic [WORD_W-1:0] ex_rtdat,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              fwd_regWr,
    output logic [REG_W-1:0]  fwd_regDst,
    output logic [WORD_W-1:0] fwd_dat,
    output logic              wb_regWr,
    output logic [REG_W-1:0]  wb_regDst,
    output logic [WORD_W-1:0] wb_wdat
);

    exmem_t            exmem_q;
    exmem_t            ex_cap_c;
    memwb_t            memwb_q;
    memwb_t            memwb_c;
    logic              advance_c;
    logic              start_c;
    logic [WORD_W-1:0] load_q;
    logic              ld_valid;

    assign advance_c = ihit & ~mem_stall;

    // Value captured into EX/MEM on advance; flush inserts a bubble.
    always_comb begin
        ex_cap_c = '0;
        if (!flush) begin
            ex_cap_c.npc    = ex_nPC;
            ex_cap_c.dren   = ex_dREN;
            ex_cap_c.dwen   = ex_dWEN;
            ex_cap_c.regwr  = ex_regWr;
            ex_cap_c.regsel = regsel_t'(ex_regSel);
            ex_cap_c.regdst = ex_regDst;
            ex_cap_c.aluout = ex_ALUOut;
            ex_cap_c.rtdat  = ex_rtdat;
        end
    end

    assign start_c = advance_c & (ex_cap_c.dren | ex_cap_c.dwen);

    dmem_req_fsm u_req (
        .CLK       (CLK),
        .RST       (RST),
        .advance   (advance_c),
        .start     (start_c),
        .dren      (exmem_q.dren),
        .dwen      (exmem_q.dwen),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .mem_stall (mem_stall),
        .load_q    (load_q),
        .ld_valid  (ld_valid)
    );

    // EX/MEM latch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exmem_q <= '0;
        end else if (advance_c) begin
            exmem_q <= ex_cap_c;
        end
    end

    // Write-back select; load data comes live from the dcache unless it was
    // parked in load_q during an ihit stall.
    always_comb begin
        memwb_c        = '0;
        memwb_c.regwr  = exmem_q.regwr;
        memwb_c.regdst = exmem_q.regdst;
        case (exmem_q.regsel)
            REG_LOAD: memwb_c.wdat = ld_valid ? load_q : dmemload;
            REG_LINK: memwb_c.wdat = exmem_q.npc;
            default:  memwb_c.wdat = exmem_q.aluout;
        endcase
    end

    // MEM/WB latch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            memwb_q <= '0;
        end else if (advance_c) begin
            memwb_q <= memwb_c;
        end
    end

    assign dmemaddr   = word_align(exmem_q.aluout);
    assign dmemstore  = exmem_q.rtdat;

    // Loads are never forwarded from here; the hazard unit stalls load-use.
    assign fwd_regWr  = exmem_q.regwr & (exmem_q.regsel != REG_LOAD);
    assign fwd_regDst = exmem_q.regdst;
    assign fwd_dat    = (exmem_q.regsel == REG_LINK) ? exmem_q.npc : exmem_q.aluout;

    assign wb_regWr   = memwb_q.regwr;
    assign wb_regDst  = memwb_q.regdst;
    assign wb_wdat    = memwb_q.wdat;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic        flush;
    logic [31:0] ex_nPC;
    logic        ex_dREN;
    logic        ex_dWEN;
    logic        ex_regWr;
    logic [1:0]  ex_regSel;
    logic [4:0]  ex_regDst;
    logic [31:0] ex_ALUOut;
    logic [31:0] ex_rtdat;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        mem_stall;
    logic        fwd_regWr;
    logic [4:0]  fwd_regDst;
    logic [31:0] fwd_dat;
    logic        wb_regWr;
    logic [4:0]  wb_regDst;
    logic [31:0] wb_wdat;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .flush      (flush),
        .ex_nPC     (ex_nPC),
        .ex_dREN    (ex_dREN),
        .ex_dWEN    (ex_dWEN),
        .ex_regWr   (ex_regWr),
        .ex_regSel  (ex_regSel),
        .ex_regDst  (ex_regDst),
        .ex_ALUOut  (ex_ALUOut),
        .ex_rtdat   (ex_rtdat),
        .dhit       (dhit),
        .dmemload   (dmemload),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .mem_stall  (mem_stall),
        .fwd_regWr  (fwd_regWr),
        .fwd_regDst (fwd_regDst),
        .fwd_dat    (fwd_dat),
        .wb_regWr   (wb_regWr),
        .wb_regDst  (wb_regDst),
        .wb_wdat    (wb_wdat)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] npc, input logic dren, input logic dwen,
                          input logic regwr, input logic [1:0] regsel,
                          input logic [4:0] regdst, input logic [31:0] alu,
                          input logic [31:0] rt);
        ex_nPC    = npc;
        ex_dREN   = dren;
        ex_dWEN   = dwen;
        ex_regWr  = regwr;
        ex_regSel = regsel;
        ex_regDst = regdst;
        ex_ALUOut = alu;
        ex_rtdat  = rt;
    endtask

    task automatic nop();
        set_ex(32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        RST = 1'b1; ihit = 1'b0; flush = 1'b0; dhit = 1'b0; dmemload = 32'h0;
        set_ex(32'h44, 1'b1, 1'b0, 1'b1, 2'd1, 5'd3, 32'h88, 32'h99);
        #2;
        total++;
        if ({dmemREN, dmemWEN, mem_stall, fwd_regWr, wb_regWr} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000", {dmemREN, dmemWEN, mem_stall, fwd_regWr, wb_regWr});
        end
        total++;
        if ({dmemaddr, dmemstore, wb_wdat, fwd_dat} !== 128'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {dmemaddr, dmemstore, wb_wdat, fwd_dat});
        end
        step();
        RST = 1'b0;
        nop();
        step();
    endtask

    task automatic test_alu();
        ihit = 1'b1;
        set_ex(32'h4, 1'b0, 1'b0, 1'b1, 2'd0, 5'd5, 32'h1234, 32'h0);
        step();
        nop();
        #1;
        total++;
        if ({fwd_regWr, fwd_regDst, fwd_dat} !== {1'b1, 5'd5, 32'h1234}) begin
            bad++;
            $display("FAIL alu_fwd got=%b/%0d/%h exp=1/5/00001234", fwd_regWr, fwd_regDst, fwd_dat);
        end
        total++;
        if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
            bad++;
            $display("FAIL alu_noreq got=%b exp=000", {dmemREN, dmemWEN, mem_stall});
        end
        step();
        total++;
        if ({wb_regWr, wb_regDst, wb_wdat} !== {1'b1, 5'd5, 32'h1234}) begin
            bad++;
            $display("FAIL alu_wb got=%b/%0d/%h exp=1/5/00001234", wb_regWr, wb_regDst, wb_wdat);
        end
    endtask

    task automatic test_load();
        ihit = 1'b1;
        set_ex(32'h8, 1'b1, 1'b0, 1'b1, 2'd1, 5'd7, 32'h103, 32'h0);
        step();
        nop();
        for (int c = 0; c < 3; c++) begin
            dhit     = (c == 2);
            dmemload = (c == 2) ? 32'hDEADBEEF : 32'h0BAD0BAD;
            #1;
            total++;
            if ({dmemREN, dmemWEN, mem_stall, dmemaddr} !== {1'b1, 1'b0, (c != 2), 32'h100}) begin
                bad++;
                $display("FAIL load_req cyc=%0d got=%b%b%b/%h exp=10%b/00000100", c, dmemREN, dmemWEN, mem_stall, dmemaddr, (c != 2));
            end
            if (c == 0) begin
                total++;
                if (fwd_regWr !== 1'b0) begin
                    bad++;
                    $display("FAIL load_nofwd got=%b exp=0", fwd_regWr);
                end
            end
            step();
        end
        dhit = 1'b0; dmemload = 32'h0;
        #1;
        total++;
        if ({dmemREN, mem_stall, wb_regWr, wb_regDst, wb_wdat} !== {1'b0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL load_wb got=%b%b/%b/%0d/%h exp=00/1/7/deadbeef", dmemREN, mem_stall, wb_regWr, wb_regDst, wb_wdat);
        end
    endtask

    task automatic test_load_ihit_stall();
        ihit = 1'b1;
        set_ex(32'hC, 1'b1, 1'b0, 1'b1, 2'd1, 5'd8, 32'h300, 32'h0);
        step();
        nop();
        ihit = 1'b0; dhit = 1'b1; dmemload = 32'hDEADBEEF;
        #1;
        total++;
        if ({dmemREN, mem_stall} !== 2'b10) begin
            bad++;
            $display("FAIL ldst_hit got=%b exp=10", {dmemREN, mem_stall});
        end
        step();
        dhit = 1'b0; dmemload = 32'h11111111;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({dmemREN, mem_stall, wb_regWr, wb_wdat} !== {3'b000, 32'h0}) begin
                bad++;
                $display("FAIL ldst_hold cyc=%0d got=%b%b%b/%h exp=000/00000000", c, dmemREN, mem_stall, wb_regWr, wb_wdat);
            end
            step();
        end
        ihit = 1'b1;
        step();
        total++;
        if ({wb_regWr, wb_regDst, wb_wdat} !== {1'b1, 5'd8, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL ldst_wb got=%b/%0d/%h exp=1/8/deadbeef", wb_regWr, wb_regDst, wb_wdat);
        end
        dmemload = 32'h0;
    endtask

    task automatic test_store();
        ihit = 1'b1;
        set_ex(32'h10, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'h204, 32'hCAFEF00D);
        step();
        nop();
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({dmemREN, dmemWEN, mem_stall, dmemaddr, dmemstore} !== {3'b011, 32'h204, 32'hCAFEF00D}) begin
                bad++;
                $display("FAIL store_req cyc=%0d got=%b%b%b/%h/%h exp=011/00000204/cafef00d", c, dmemREN, dmemWEN, mem_stall, dmemaddr, dmemstore);
            end
            step();
        end
        dhit = 1'b1;
        #1;
        total++;
        if ({dmemWEN, mem_stall} !== 2'b10) begin
            bad++;
            $display("FAIL store_hit got=%b exp=10", {dmemWEN, mem_stall});
        end
        step();
        dhit = 1'b0;
        #1;
        total++;
        if ({dmemWEN, mem_stall, wb_regWr} !== 3'b000) begin
            bad++;
            $display("FAIL store_wb got=%b exp=000", {dmemWEN, mem_stall, wb_regWr});
        end
    endtask

    task automatic test_jal_flush();
        ihit = 1'b1;
        set_ex(32'h40, 1'b0, 1'b0, 1'b1, 2'd2, 5'd31, 32'h999, 32'h0);
        step();
        total++;
        if ({fwd_regWr, fwd_dat} !== {1'b1, 32'h40}) begin
            bad++;
            $display("FAIL jal_fwd got=%b/%h exp=1/00000040", fwd_regWr, fwd_dat);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        nop();
        #1;
        total++;
        if ({wb_regWr, wb_regDst, wb_wdat} !== {1'b1, 5'd31, 32'h40}) begin
            bad++;
            $display("FAIL jal_wb got=%b/%0d/%h exp=1/31/00000040", wb_regWr, wb_regDst, wb_wdat);
        end
        total++;
        if (fwd_regWr !== 1'b0) begin
            bad++;
            $display("FAIL flush_fwd got=%b exp=0", fwd_regWr);
        end
        step();
        total++;
        if ({wb_regWr, wb_wdat} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL flush_wb got=%b/%h exp=0/00000000", wb_regWr, wb_wdat);
        end
    endtask

    task automatic test_reset_mid_access();
        ihit = 1'b1;
        set_ex(32'h50, 1'b0, 1'b0, 1'b1, 2'd0, 5'd9, 32'h55, 32'h0);
        step();
        set_ex(32'h54, 1'b1, 1'b0, 1'b1, 2'd1, 5'd10, 32'h400, 32'h0);
        step();
        nop();
        #1;
        total++;
        if ({dmemREN, mem_stall, wb_regWr, wb_wdat} !== {3'b111, 32'h55}) begin
            bad++;
            $display("FAIL rstmid_pre got=%b%b%b/%h exp=111/00000055", dmemREN, mem_stall, wb_regWr, wb_wdat);
        end
        RST = 1'b1;
        #1;
        total++;
        if ({dmemREN, mem_stall, wb_regWr, wb_regDst, wb_wdat, dmemaddr} !== {3'b000, 5'd0, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL rstmid got=%b%b%b/%0d/%h/%h exp=000/0/0/0", dmemREN, mem_stall, wb_regWr, wb_regDst, wb_wdat, dmemaddr);
        end
        step();
        RST = 1'b0;
        set_ex(32'h58, 1'b0, 1'b0, 1'b1, 2'd0, 5'd11, 32'h77, 32'h0);
        step();
        nop();
        #1;
        total++;
        if ({dmemREN, dmemWEN, mem_stall, fwd_dat} !== {3'b000, 32'h77}) begin
            bad++;
            $display("FAIL rstmid_idle got=%b%b%b/%h exp=000/00000077", dmemREN, dmemWEN, mem_stall, fwd_dat);
        end
        step();
        total++;
        if ({wb_regWr, wb_regDst, wb_wdat} !== {1'b1, 5'd11, 32'h77}) begin
            bad++;
            $display("FAIL rstmid_wb got=%b/%0d/%h exp=1/11/00000077", wb_regWr, wb_regDst, wb_wdat);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_load_ihit_stall();
        test_store();
        test_jal_flush();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
